// File: rtl/lr35902_oam_dma.sv
// lr35902_oam_dma: OAM DMA engine.
//   A CPU write to the DMA register latches the source page. The engine then
//   copies XFER_LEN bytes from {page,8'h00}.. into destination indices
//   0..XFER_LEN-1. Each byte takes one CYCLES_PER_BYTE-clock slot: read
//   phases first, then a single write phase.
// Ports:
//   clk        gbclk
//   reset      synchronous, active-high
//   reg_din    CPU write data (source page)
//   reg_write  one-clock strobe, CPU write to the DMA register
//   reg_dout   source-page register readback
//   din        source read data, valid on the last read phase
//   active     transfer in progress (start delay or copying)
//   drv_ext    active and the effective source page is not VRAM
//   adr_rd     source address {eff_page, idx[7:0]}
//   rd         source read strobe
//   adr_wr     destination index
//   wr         destination write strobe
//   dout       byte being written
module lr35902_oam_dma #(
    parameter int XFER_LEN        = 160,
    parameter int CYCLES_PER_BYTE = 4,
    parameter int START_DELAY     = 8,
    parameter int WR_ADR_W        = 8,
    parameter int MIRROR_ECHO     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          reg_din,
    input  logic                reg_write,
    output logic [7:0]          reg_dout,
    input  logic [7:0]          din,
    output logic                active,
    output logic                drv_ext,
    output logic [15:0]         adr_rd,
    output logic                rd,
    output logic [WR_ADR_W-1:0] adr_wr,
    output logic                wr,
    output logic [7:0]          dout
);

    localparam int IW = $clog2(XFER_LEN + 1);
    localparam int PW = $clog2(CYCLES_PER_BYTE);
    localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(XFER_LEN - 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [PW-1:0] PH_LATCH = PW'(CYCLES_PER_BYTE - 2);
    localparam logic [DW-1:0] DLOAD    = (START_DELAY > 0) ? DW'(START_DELAY - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        XFER
    } state_t;

    state_t        state, state_d;
    logic [7:0]    src_hi, src_d;
    logic [IW-1:0] idx, idx_d;
    logic [PW-1:0] phase, phase_d;
    logic [DW-1:0] dcnt, dcnt_d;
    logic [7:0]    dout_d;
    logic [7:0]    eff_page;
    logic [7:0]    idx8;

    // Echo RAM (E000-FFFF) aliases C000-DFFF.
    always_comb begin
        if (MIRROR_ECHO != 0 && src_hi >= 8'hE0)
            eff_page = src_hi - 8'h20;
        else
            eff_page = src_hi;
    end

    generate
        if (IW >= 8) begin : g_idx_wide
            assign idx8 = idx[7:0];
        end else begin : g_idx_narrow
            assign idx8 = {{(8 - IW){1'b0}}, idx};
        end
    endgenerate

    assign reg_dout = src_hi;
    assign adr_rd   = {eff_page, idx8};
    assign adr_wr   = WR_ADR_W'(idx);
    assign drv_ext  = active && (eff_page[7:5] != 3'b100);

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            src_hi <= '0;
            idx    <= '0;
            phase  <= '0;
            dcnt   <= '0;
            dout   <= '0;
        end else begin
            state  <= state_d;
            src_hi <= src_d;
            idx    <= idx_d;
            phase  <= phase_d;
            dcnt   <= dcnt_d;
            dout   <= dout_d;
        end
    end

    always_comb begin
        state_d = state;
        src_d   = src_hi;
        idx_d   = idx;
        phase_d = phase;
        dcnt_d  = dcnt;
        dout_d  = dout;
        active  = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;

        unique case (state)
            IDLE: ;
            DELAY: begin
                active = 1'b1;
                if (dcnt == '0) begin
                    state_d = XFER;
                    phase_d = '0;
                end else begin
                    dcnt_d = dcnt - 1'b1;
                end
            end
            XFER: begin
                active = 1'b1;
                if (phase == PH_LAST) begin
                    wr      = 1'b1;
                    phase_d = '0;
                    idx_d   = idx + 1'b1;
                    if (idx == LAST_IDX)
                        state_d = IDLE;
                end else begin
                    rd      = 1'b1;
                    phase_d = phase + 1'b1;
                    if (phase == PH_LATCH)
                        dout_d = din;
                end
            end
            default: state_d = IDLE;
        endcase

        // A register write (re)starts the transfer from any state; a write
        // slot coinciding with it is dropped so no stale byte lands.
        if (reg_write) begin
            src_d   = reg_din;
            idx_d   = '0;
            phase_d = '0;
            dcnt_d  = DLOAD;
            wr      = 1'b0;
            if (START_DELAY == 0)
                state_d = XFER;
            else
                state_d = DELAY;
        end
    end

endmodule

// File: tb/tb_lr35902_oam_dma.sv
module tb_lr35902_oam_dma;

    typedef struct {
        logic [7:0]  adr;
        logic [7:0]  data;
        logic [15:0] ra;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // ---------------- instance A: default parameters ----------------
    logic        a_reset, a_reg_write, a_active, a_drv, a_rd, a_wr;
    logic [7:0]  a_reg_din, a_reg_dout, a_din, a_adr_wr, a_dout;
    logic [15:0] a_adr_rd;

    // ---------------- instance B: 256 bytes, 2 clocks/byte, no delay ----
    logic        b_reset, b_reg_write, b_active, b_drv, b_rd, b_wr;
    logic [7:0]  b_reg_din, b_reg_dout, b_din, b_adr_wr, b_dout;
    logic [15:0] b_adr_rd;

    exp_t qa[$];
    exp_t qb[$];
    int   a_wr_cnt = 0;
    int   b_wr_cnt = 0;
    logic [7:0] exp_src = 8'h00;
    logic       exp_ext = 1'b0;

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
    endfunction

    function automatic logic [7:0] effp(input logic [7:0] v);
        return (v >= 8'hE0) ? v - 8'h20 : v;
    endfunction

    assign a_din = src_byte(a_adr_rd);
    assign b_din = src_byte(b_adr_rd);

    lr35902_oam_dma u_a (
        .clk(clk), .reset(a_reset), .reg_din(a_reg_din), .reg_write(a_reg_write),
        .reg_dout(a_reg_dout), .din(a_din), .active(a_active), .drv_ext(a_drv),
        .adr_rd(a_adr_rd), .rd(a_rd), .adr_wr(a_adr_wr), .wr(a_wr), .dout(a_dout)
    );

    lr35902_oam_dma #(
        .XFER_LEN(256), .CYCLES_PER_BYTE(2), .START_DELAY(0), .WR_ADR_W(8), .MIRROR_ECHO(1)
    ) u_b (
        .clk(clk), .reset(b_reset), .reg_din(b_reg_din), .reg_write(b_reg_write),
        .reg_dout(b_reg_dout), .din(b_din), .active(b_active), .drv_ext(b_drv),
        .adr_rd(b_adr_rd), .rd(b_rd), .adr_wr(b_adr_wr), .wr(b_wr), .dout(b_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is positioned #1 after a rising edge; the write is taken on the next edge.
    task automatic a_write(input logic [7:0] v);
        qa.delete();
        for (int i = 0; i < 160; i++)
            qa.push_back('{adr: 8'(i), data: src_byte({effp(v), 8'(i)}), ra: {effp(v), 8'(i)}});
        a_wr_cnt    = 0;
        a_reg_din   = v;
        a_reg_write = 1'b1;
        @(posedge clk); #1;
        a_reg_write = 1'b0;
        exp_src     = v;
        exp_ext     = (effp(v) >> 5) != 8'd4;
    endtask

    task automatic b_write(input logic [7:0] v);
        qb.delete();
        for (int i = 0; i < 256; i++)
            qb.push_back('{adr: 8'(i), data: src_byte({effp(v), 8'(i)}), ra: {effp(v), 8'(i)}});
        b_wr_cnt    = 0;
        b_reg_din   = v;
        b_reg_write = 1'b1;
        @(posedge clk); #1;
        b_reg_write = 1'b0;
    endtask

    task automatic a_run(input string tag, input int exp_len);
        int n = 0;
        while (a_active === 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_active_len"}, n, exp_len);
        chk({tag, "_wr_count"}, a_wr_cnt, 160);
        chk({tag, "_queue_left"}, qa.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("a_rd_wr_excl", a_rd & a_wr, 0);
        chk("a_reg_dout", a_reg_dout, exp_src);
        chk("a_drv_ext", a_drv, a_active ? exp_ext : 1'b0);
        if (a_rd === 1'b1 && qa.size() > 0)
            chk("a_adr_rd", a_adr_rd, qa[0].ra);
        if (a_wr === 1'b1) begin
            a_wr_cnt++;
            if (qa.size() == 0) begin
                chk("a_unexpected_wr", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_adr_wr", a_adr_wr, e.adr);
                chk("a_dout", a_dout, e.data);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        chk("b_rd_wr_excl", b_rd & b_wr, 0);
        if (b_rd === 1'b1 && qb.size() > 0)
            chk("b_adr_rd", b_adr_rd, qb[0].ra);
        if (b_wr === 1'b1) begin
            b_wr_cnt++;
            if (qb.size() == 0) begin
                chk("b_unexpected_wr", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_adr_wr", b_adr_wr, e.adr);
                chk("b_dout", b_dout, e.data);
            end
        end
    end

    initial begin
        int n;
        bit found;
        a_reset = 1'b1; a_reg_write = 1'b0; a_reg_din = 8'h00;
        b_reset = 1'b1; b_reg_write = 1'b0; b_reg_din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset state
        chk("rst_active", a_active, 0);
        chk("rst_rd", a_rd, 0);
        chk("rst_wr", a_wr, 0);
        chk("rst_adr_rd", a_adr_rd, 16'h0000);
        chk("rst_adr_wr", a_adr_wr, 8'h00);
        chk("rst_dout", a_dout, 8'h00);
        chk("rst_reg_dout", a_reg_dout, 8'h00);
        chk("rst_b_active", b_active, 0);
        @(posedge clk); #1;

        // Plain transfer from C1
        a_write(8'hC1);
        a_run("t1", 8 + 640);
        chk("t1_reg_dout", a_reg_dout, 8'hC1);
        repeat (3) @(posedge clk); #1;

        // Echo page E2 reads C2xx, external bus
        a_write(8'hE2);
        chk("t2_drv_ext", a_drv, 1);
        a_run("t2e", 8 + 640);
        @(posedge clk); #1;

        // VRAM page 85, internal bus
        a_write(8'h85);
        chk("t2v_drv_ext", a_drv, 0);
        a_run("t2v", 8 + 640);
        @(posedge clk); #1;

        // Restart on the write slot of byte 50
        a_write(8'hC3);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk); #1;
            if (a_wr === 1'b1 && a_adr_wr === 8'd50) found = 1;
        end
        chk("t3_found_byte50", found, 1);
        chk("t3_pre_count", a_wr_cnt, 50);
        a_write(8'hD0);
        chk("t3_active_kept", a_active, 1);
        a_run("t3", 8 + 640);
        @(posedge clk); #1;

        // Reset on byte 10, phase 1
        a_write(8'hC4);
        found = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk); #1;
            if (a_rd === 1'b1 && a_adr_rd === 16'hC40A) found = 1;
        end
        chk("t4_found_byte10", found, 1);
        @(posedge clk); #1;
        qa.delete();
        a_reset = 1'b1;
        @(posedge clk); #1;
        exp_src = 8'h00;
        exp_ext = 1'b0;
        chk("t4_active", a_active, 0);
        chk("t4_rd", a_rd, 0);
        chk("t4_wr", a_wr, 0);
        chk("t4_reg_dout", a_reg_dout, 8'h00);
        a_reset = 1'b0;
        repeat (50) @(posedge clk); #1;
        chk("t4_wr_count", a_wr_cnt, 10);
        chk("t4_idle", a_active, 0);

        // Instance B: 256 bytes, 2 clocks per byte, no delay
        b_write(8'h40);
        chk("t5_first_rd", b_rd, 1);
        chk("t5_first_adr", b_adr_rd, 16'h4000);
        n = 0;
        while (b_active === 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_active_len", n, 512);
        chk("t5_wr_count", b_wr_cnt, 256);
        chk("t5_queue_left", qb.size(), 0);
        chk("t5_final_adr_wr", b_adr_wr, 8'h00);
        repeat (5) @(posedge clk); #1;
        chk("t5_no_extra_wr", b_wr_cnt, 256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
